// File: rtl/loader_pkg.sv
// Shared opcodes, response bytes and FSM encodings for the UART host-command loader.
// LOADER_CHECKSUM_EN adds the CHECK state used for the trailing XOR checksum byte.
package loader_pkg;

  localparam logic [1:0] OP_PING   = 2'b00;
  localparam logic [1:0] OP_IMEM   = 2'b01;
  localparam logic [1:0] OP_BMEM   = 2'b10;
  localparam logic [1:0] OP_UPDATE = 2'b11;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_IMEM_ADDR = 3'd1,
    ST_IMEM_DATA = 3'd2,
    ST_BMEM_ADDR = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    ST_BMEM_DATA = 3'd4,
    ST_CHECK     = 3'd5
`else
    ST_BMEM_DATA = 3'd4
`endif
  } loader_state_t;

endpackage

// File: rtl/loader_resp_reg.sv
// Single-entry response holding register. Handshake: tx_data is transferred on any cycle
// where tx_valid && tx_ready; a new load in the same cycle wins and keeps tx_valid high.
module loader_resp_reg (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid
);

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_data  <= load_data;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Decodes little-endian UART command packets into IMEM/BMEM writes and run-mask updates,
// answering each command with ACK/NAK. Define LOADER_CHECKSUM_EN for a trailing XOR byte.
module uart_loader
  import loader_pkg::*;
#(
  parameter int BITWIDTH    = 32,
  parameter int NUM_THREADS = 3,
  parameter int BMEM_WORDS  = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [7:0]                       rx_data,
  input  logic                             rx_valid,
  output logic [7:0]                       tx_data,
  output logic                             tx_valid,
  input  logic                             tx_ready,
  output logic [BITWIDTH-1:0]              imem_write_addr,
  output logic [BITWIDTH-1:0]              imem_write_data,
  output logic [NUM_THREADS-1:0]           imem_write_valid,
  output logic [BITWIDTH-1:0]              bmem_write_addr,
  output logic [BMEM_WORDS*BITWIDTH-1:0]   bmem_write_data,
  output logic                             bmem_write_valid,
  output logic [NUM_THREADS-1:0]           thread_running,
  output logic                             busy,
  output logic [2:0]                       debug_state
);

  localparam int B          = BITWIDTH / 8;
  localparam int TILE_BYTES = B * BMEM_WORDS;
  localparam int CNT_W      = $clog2(TILE_BYTES) + 1;
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(B - 1);
  localparam logic [CNT_W-1:0] TILE_LAST = CNT_W'(TILE_BYTES - 1);

  loader_state_t                 state_q, state_d;
  logic [CNT_W-1:0]              cnt_q;
  logic [BITWIDTH-1:0]           addr_q, imem_data_q;
  logic [BMEM_WORDS*BITWIDTH-1:0] tile_q;
  logic [NUM_THREADS-1:0]        run_q, target, imem_strobe_q;
  logic                          bmem_strobe_q;
  logic [1:0]                    opcode;
  logic                          word_last, tile_last;
  logic                          imem_fire, bmem_fire, resp_load, run_load;
  logic [7:0]                    resp_byte;

  assign opcode    = rx_data[7:6];
  assign word_last = (cnt_q == WORD_LAST);
  assign tile_last = (cnt_q == TILE_LAST);
  // One-hot of the lowest idle thread; all-zero when every thread is running.
  assign target    = ~run_q & (run_q + NUM_THREADS'(1));

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  logic       is_bmem_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      csum_q    <= 8'h00;
      is_bmem_q <= 1'b0;
    end else if (rx_valid) begin
      if (state_q == ST_IDLE) begin
        csum_q    <= rx_data;
        is_bmem_q <= (opcode == OP_BMEM);
      end else begin
        csum_q <= csum_q ^ rx_data;
      end
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && opcode == OP_IMEM) state_d = ST_IMEM_ADDR;
        if (rx_valid && opcode == OP_BMEM) state_d = ST_BMEM_ADDR;
      end
      ST_IMEM_ADDR: if (rx_valid && word_last) state_d = ST_IMEM_DATA;
      ST_BMEM_ADDR: if (rx_valid && word_last) state_d = ST_BMEM_DATA;
`ifdef LOADER_CHECKSUM_EN
      ST_IMEM_DATA: if (rx_valid && word_last) state_d = ST_CHECK;
      ST_BMEM_DATA: if (rx_valid && tile_last) state_d = ST_CHECK;
      ST_CHECK:     if (rx_valid) state_d = ST_IDLE;
`else
      ST_IMEM_DATA: if (rx_valid && word_last) state_d = ST_IDLE;
      ST_BMEM_DATA: if (rx_valid && tile_last) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_fire = 1'b0;
    bmem_fire = 1'b0;
    resp_load = 1'b0;
    run_load  = 1'b0;
    resp_byte = ACK;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (opcode == OP_PING || opcode == OP_UPDATE)) resp_load = 1'b1;
        if (rx_valid && opcode == OP_UPDATE) run_load = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (rx_valid) begin
          resp_load = 1'b1;
          if (rx_data == csum_q) begin
            bmem_fire = is_bmem_q;
            imem_fire = !is_bmem_q && (|target);
          end
          resp_byte = (imem_fire || bmem_fire) ? ACK : NAK;
        end
      end
`else
      ST_IMEM_DATA: begin
        if (rx_valid && word_last) begin
          imem_fire = |target;
          resp_load = 1'b1;
          resp_byte = (|target) ? ACK : NAK;
        end
      end
      ST_BMEM_DATA: begin
        if (rx_valid && tile_last) begin
          bmem_fire = 1'b1;
          resp_load = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Byte position within the current field; restarts on every state change.
  always_ff @(posedge clock) begin
    if (reset)                     cnt_q <= '0;
    else if (state_d != state_q)   cnt_q <= '0;
    else if (rx_valid && state_q != ST_IDLE) cnt_q <= cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q      <= '0;
      imem_data_q <= '0;
      tile_q      <= '0;
    end else if (rx_valid) begin
      case (state_q)
        ST_IMEM_ADDR, ST_BMEM_ADDR: addr_q[{cnt_q, 3'b000} +: 8] <= rx_data;
        ST_IMEM_DATA: imem_data_q[{cnt_q, 3'b000} +: 8] <= rx_data;
        ST_BMEM_DATA: tile_q[{cnt_q, 3'b000} +: 8] <= rx_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      imem_strobe_q <= '0;
      bmem_strobe_q <= 1'b0;
      run_q         <= '0;
    end else begin
      imem_strobe_q <= imem_fire ? target : '0;
      bmem_strobe_q <= bmem_fire;
      if (run_load) run_q <= rx_data[NUM_THREADS-1:0];
    end
  end

  loader_resp_reg u_resp (
    .clock     (clock),
    .reset     (reset),
    .load      (resp_load),
    .load_data (resp_byte),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid)
  );

  assign imem_write_addr  = addr_q;
  assign imem_write_data  = imem_data_q;
  assign imem_write_valid = imem_strobe_q;
  assign bmem_write_addr  = addr_q;
  assign bmem_write_data  = tile_q;
  assign bmem_write_valid = bmem_strobe_q;
  assign thread_running   = run_q;
  assign busy             = (state_q != ST_IDLE);
  assign debug_state      = state_q;

endmodule
